// File: rtl/acc_drain_mux_if.sv
// Handshake bundle for acc_drain_mux: NCH valid/ready input channels and
// one valid/ready output carrying the result word and its source channel.
interface acc_drain_mux_if #(
  parameter int NCH = 4,
  parameter int W   = 26
);
  localparam int CW = $clog2(NCH);

  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_ch;
  logic             out_valid;
  logic             out_ready;

  // master is the producer/consumer side around the drain stage
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/acc_drain_mux.sv
// Registered N-channel drain stage: one capture buffer per channel feeding a
// single output register, arbitrated round-robin or by a fixed channel index.
module acc_drain_mux #(
  parameter int  M   = 16,
  parameter int  Pa  = 8,
  parameter int  Pw  = 4,
  parameter int  MNO = 288,
  parameter int  NCH = 4,
  localparam int W   = $clog2(M) + Pa + Pw + $clog2(MNO) + 1,
  localparam int CW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode_i,
  input  logic [CW-1:0]   sel_i,
  acc_drain_mux_if.slave  bus
);

  logic [NCH-1:0] pend_q, pend_d;
  logic [W-1:0]   buf_q [NCH];
  logic [W-1:0]   buf_d [NCH];
  logic [W-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic           out_valid_q, out_valid_d;
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             can_load;
  logic             grant_any;
  logic [CW-1:0]    grant_idx;
  logic [2**CW-1:0] pend_ext;
  logic [CW:0]      idx;

  assign bus.in_ready  = ~pend_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

  // Zero-padding pend to a power of two makes sel_i >= NCH see "nothing pending".
  always_comb begin
    pend_ext            = '0;
    pend_ext[NCH-1:0]   = pend_q;
    can_load            = ~out_valid_q | bus.out_ready;
    grant_any           = 1'b0;
    grant_idx           = '0;
    idx                 = '0;
    if (can_load) begin
      if (mode_i) begin
        if (pend_ext[sel_i]) begin
          grant_any = 1'b1;
          grant_idx = sel_i;
        end
      end else begin
        for (int j = 0; j < NCH; j++) begin
          idx = {1'b0, rr_ptr_q} + (CW+1)'(j);
          if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
          if (!grant_any && pend_ext[idx[CW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = idx[CW-1:0];
          end
        end
      end
    end
  end

  // NOTE: every _d starts from its _q value, so no branch can leave a latch behind.
  always_comb begin
    pend_d      = pend_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;

    for (int i = 0; i < NCH; i++) begin
      if (bus.in_valid[i] && !pend_q[i]) begin
        buf_d[i]  = bus.in_data[i*W +: W];
        pend_d[i] = 1'b1;
      end
    end

    // A captured channel is never the granted one: capture needs pend=0, grant pend=1.
    if (can_load) begin
      if (grant_any) begin
        out_data_d          = buf_q[grant_idx];
        out_ch_d            = grant_idx;
        out_valid_d         = 1'b1;
        pend_d[grant_idx]   = 1'b0;
        if (!mode_i) begin
          rr_ptr_d = (int'(grant_idx) == NCH-1) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      // NOTE: the capture buffers are cleared as well, so a reset discards every held word.
      for (int i = 0; i < NCH; i++) buf_q[i] <= '0;
    end else begin
      pend_q      <= pend_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule
